hls_test_runner: RTL
====================

Name: hls_test_runner

Overview:
- Synthesizable upstream driver for Synthesijer-generated test methods. It takes the place of the bench-side request logic in front of one or more `TestNNN` cores.
- Sequences N method calls, one at a time, each over the req/busy/return handshake. Enforces a start delay and per-test timeouts, then aggregates pass/fail.
- Feeds `test_req` into each core and consumes `test_busy` / `test_return`. Top-level sim or board LEDs read `done` / `pass`.

Parameters:
- N_TESTS, 4, number of method cores driven (1..32).
- START_DELAY, 100, idle cycles after `start` before the first request.
- ACK_TIMEOUT, 16, max cycles from `req` asserted to `busy` seen high.
- RUN_TIMEOUT, 10000, max cycles from `busy` high to `busy` low.
- CW, 32, width of cycle counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- start  in  1  level or pulse; sampled only in IDLE.
- test_req  out  N_TESTS  one-hot request to core i.
- test_busy  in  N_TESTS  busy from core i.
- test_return  in  N_TESTS  boolean return from core i; valid when its busy falls.
- done  out  1  high once all tests finished; held until reset or a new start.
- pass  out  1  valid when done=1; 1 iff fail_mask==0 and timeout_mask==0.
- fail_mask  out  N_TESTS  bit i=1: test i completed with return==0.
- timeout_mask  out  N_TESTS  bit i=1: test i hit an ack or run timeout.
- cur_index  out  5  index of the test in progress.
- last_cycles  out  CW  busy-high cycle count of the most recently finished test.

Behaviour:
- Reset: all outputs are 0, state=IDLE, counters=0. Reset asserted mid-run aborts immediately and drops test_req in the same cycle (async).
- FSM states: IDLE, DELAY, REQ, RUN, CHECK, NEXT, DONE.
- IDLE -> DELAY on start=1.
  - Clears done, pass, fail_mask, timeout_mask, last_cycles, and sets cur_index=0.
  - Loads the delay counter.
- DELAY: counts START_DELAY cycles. START_DELAY=0 goes straight to REQ next cycle.
- REQ: test_req[cur_index]=1, other bits 0.
  - Sampled test_busy[cur_index]=1 -> RUN; req deasserts on the same transition.
  - ACK_TIMEOUT cycles with busy low -> set timeout_mask[cur_index], go NEXT.
- RUN: test_req=0; last_cycles increments each cycle busy is high.
  - busy=0 sampled -> CHECK.
  - last_cycles reaching RUN_TIMEOUT -> set timeout_mask bit, go NEXT. The core is left running; no further request is issued to it.
- CHECK: one cycle. Samples test_return[cur_index]; 0 sets the fail_mask bit.
- NEXT: if cur_index==N_TESTS-1 -> DONE, else cur_index+1 -> DELAY with a 1-cycle delay (inter-test gap).
- DONE: done=1, pass registered. start=1 while in DONE restarts as from IDLE.
- Busy glitches on non-selected cores are ignored. Only bit cur_index is observed.
- Busy already high on entry to REQ (stale) counts as the acknowledge. It is not treated as an error.
- last_cycles saturates at 2^CW-1; it never wraps.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- N_TESTS=1: stub core raises busy 1 cycle after req, holds 20 cycles, returns 1 -> req first high at cycle START_DELAY+1 after start; done=1, pass=1, last_cycles=20.
- N_TESTS=4, core 2 returns 0, others 1 -> fail_mask=4'b0100, timeout_mask=0, pass=0. Requests are issued strictly in order 0,1,2,3.
- Core 1 never raises busy -> timeout_mask[1]=1 exactly ACK_TIMEOUT cycles after its req rises; remaining tests still run; pass=0.
- Core 0 busy stuck high, RUN_TIMEOUT=50 -> timeout_mask[0]=1 and last_cycles=50; sequence continues.
- Assert reset=0 during RUN of test 2 -> test_req=0 and all outputs 0 immediately. A new start reruns from index 0.
- start held high through DONE -> a second full pass runs, and the masks are cleared at restart.

Source files
------------

// File: rtl/hls_test_runner.sv
`default_nettype none
// =====================================================================
// Module : hls_test_runner
// Drives N method cores one at a time over req/busy/return, applying a
// start delay and ack/run timeouts, and aggregates pass/fail.
// Rev    : 1.0  initial release
// =====================================================================
module hls_test_runner #(
  parameter int N_TESTS     = 4,
  parameter int START_DELAY = 100,
  parameter int ACK_TIMEOUT = 16,
  parameter int RUN_TIMEOUT = 10000,
  parameter int CW          = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [N_TESTS-1:0] test_req,
  input  logic [N_TESTS-1:0] test_busy,
  input  logic [N_TESTS-1:0] test_return,
  output logic               done,
  output logic               pass,
  output logic [N_TESTS-1:0] fail_mask,
  output logic [N_TESTS-1:0] timeout_mask,
  output logic [4:0]         cur_index,
  output logic [CW-1:0]      last_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_REQ   = 3'd2,
    S_RUN   = 3'd3,
    S_CHECK = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [CW-1:0]      C_START_DELAY = CW'(START_DELAY);
  localparam logic [CW-1:0]      C_ACK_LIMIT   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0]      C_RUN_TIMEOUT = CW'(RUN_TIMEOUT);
  localparam logic [CW-1:0]      C_CW_ONE      = CW'(1);
  localparam logic [4:0]         C_LAST_IDX    = 5'(N_TESTS - 1);
  localparam logic [N_TESTS-1:0] C_ONE         = N_TESTS'(1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [4:0]         r_idx, w_idx_nxt;
  logic [N_TESTS-1:0] r_req, w_req_nxt;
  logic [N_TESTS-1:0] r_fail, w_fail_nxt;
  logic [N_TESTS-1:0] r_tmo, w_tmo_nxt;
  logic [CW-1:0]      r_last, w_last_nxt;
  logic               r_done, w_done_nxt;
  logic               r_pass, w_pass_nxt;

  logic [N_TESTS-1:0] w_sel;
  logic               w_busy_sel;
  logic               w_ret_sel;
  logic [CW-1:0]      w_last_inc;

  // Only the selected core's busy/return bits are ever observed.
  assign w_sel      = C_ONE << r_idx;
  assign w_busy_sel = |(test_busy & w_sel);
  assign w_ret_sel  = |(test_return & w_sel);
  assign w_last_inc = (&r_last) ? r_last : r_last + C_CW_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_fail_nxt  = r_fail;
    w_tmo_nxt   = r_tmo;
    w_last_nxt  = r_last;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_DELAY;
          w_cnt_nxt   = C_START_DELAY;
          w_idx_nxt   = '0;
          w_fail_nxt  = '0;
          w_tmo_nxt   = '0;
          w_last_nxt  = '0;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_DELAY: begin
        // Counter leaves DELAY at zero, ready to time the acknowledge.
        if (r_cnt == '0) begin
          w_state_nxt = S_REQ;
          w_last_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_CW_ONE;
        end
      end
      S_REQ: begin
        if (w_busy_sel) begin
          w_state_nxt = S_RUN;
          w_last_nxt  = C_CW_ONE;
        end else if (r_cnt == C_ACK_LIMIT) begin
          w_tmo_nxt   = r_tmo | w_sel;
          w_state_nxt = S_NEXT;
        end else begin
          w_cnt_nxt = r_cnt + C_CW_ONE;
        end
      end
      S_RUN: begin
        if (!w_busy_sel) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_last_nxt = w_last_inc;
          if (w_last_inc >= C_RUN_TIMEOUT) begin
            w_tmo_nxt   = r_tmo | w_sel;
            w_state_nxt = S_NEXT;
          end
        end
      end
      S_CHECK: begin
        if (!w_ret_sel) w_fail_nxt = r_fail | w_sel;
        w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_idx == C_LAST_IDX) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (r_fail == '0) && (r_tmo == '0);
        end else begin
          w_idx_nxt   = r_idx + 5'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DELAY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req_nxt = (w_state_nxt == S_REQ) ? (C_ONE << w_idx_nxt) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_req   <= '0;
      r_fail  <= '0;
      r_tmo   <= '0;
      r_last  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_req   <= w_req_nxt;
      r_fail  <= w_fail_nxt;
      r_tmo   <= w_tmo_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign test_req     = r_req;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_mask    = r_fail;
  assign timeout_mask = r_tmo;
  assign cur_index    = r_idx;
  assign last_cycles  = r_last;

endmodule
`default_nettype wire
